// File: rtl/maxnet_controller.sv
// Sequencing FSM for the 4-neuron Maxnet datapath: initial load, then PU/activation inhibition passes.
// Optional MAXNET_ITER_REPORT_EN exposes the iteration counter as iter_count.
module maxnet_controller #(
    parameter int PU_LATENCY = 2,
    parameter int MAX_ITER   = 16,
    parameter int ITER_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              done,
    output logic              ld_x,
    output logic              ld_t,
    output logic              sel_t,
    output logic              busy,
    output logic              result_valid,
    output logic              error,
`ifdef MAXNET_ITER_REPORT_EN
    output logic [ITER_W-1:0] iter_count,
`endif
    output logic [2:0]        state_dbg
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        INIT   = 3'd1,
        CHECK  = 3'd2,
        WAIT   = 3'd3,
        UPDATE = 3'd4,
        FINISH = 3'd5
    } state_t;

    localparam logic [3:0]        WAIT_LOAD = 4'(PU_LATENCY - 1);
    localparam logic [ITER_W-1:0] ITER_MAX  = ITER_W'(MAX_ITER);

    state_t            state_q;
    state_t            state_d;
    logic              err_d;
    logic [3:0]        wcnt_q;
    logic [ITER_W-1:0] iter_q;

    always_comb begin
        state_d = state_q;
        err_d   = error;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = INIT;
                    err_d   = 1'b0;
                end
            end
            INIT:   state_d = CHECK;
            // done takes priority over the iteration cap
            CHECK: begin
                if (done) begin
                    state_d = FINISH;
                end else if (iter_q == ITER_MAX) begin
                    state_d = FINISH;
                    err_d   = 1'b1;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT:   if (wcnt_q == 4'd0) state_d = UPDATE;
            UPDATE: state_d = CHECK;
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they track state_q exactly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            error        <= 1'b0;
            wcnt_q       <= 4'd0;
            iter_q       <= '0;
            ld_x         <= 1'b0;
            ld_t         <= 1'b0;
            sel_t        <= 1'b0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            state_q      <= state_d;
            error        <= err_d;
            ld_x         <= (state_d == INIT);
            ld_t         <= (state_d == INIT) || (state_d == UPDATE);
            sel_t        <= (state_d == INIT);
            busy         <= (state_d != IDLE);
            result_valid <= (state_d == FINISH) && !err_d;

            if (state_q == CHECK) begin
                wcnt_q <= WAIT_LOAD;
            end else if (state_q == WAIT && wcnt_q != 4'd0) begin
                wcnt_q <= wcnt_q - 4'd1;
            end

            if (state_q == IDLE && start) begin
                iter_q <= '0;
            end else if (state_q == UPDATE && iter_q != ITER_MAX) begin
                iter_q <= iter_q + 1'b1;
            end
        end
    end

    assign state_dbg = state_q;
`ifdef MAXNET_ITER_REPORT_EN
    assign iter_count = iter_q;
`endif

endmodule

// File: tb/tb_maxnet_controller.sv
// Scoreboard bench for maxnet_controller: driver pushes an expected run record, monitor
// rebuilds the observed record from the outputs at the end of each run and compares.
module tb_maxnet_controller;

    localparam int PL = 2;
    localparam int MI = 4;
    localparam int IW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          done = 1'b0;
    logic          ld_x, ld_t, sel_t, busy, result_valid, error;
    logic [2:0]    state_dbg;
`ifdef MAXNET_ITER_REPORT_EN
    logic [IW-1:0] iter_count;
`endif

    maxnet_controller #(.PU_LATENCY(PL), .MAX_ITER(MI), .ITER_W(IW)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .done         (done),
        .ld_x         (ld_x),
        .ld_t         (ld_t),
        .sel_t        (sel_t),
        .busy         (busy),
        .result_valid (result_valid),
        .error        (error),
`ifdef MAXNET_ITER_REPORT_EN
        .iter_count   (iter_count),
`endif
        .state_dbg    (state_dbg)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Run record: inits | update pulses | last busy cycle | final iter | result_valid | error
    function automatic logic [31:0] pack(input int inits, input int upd, input int fin,
                                         input int iter, input bit rv, input bit err);
`ifdef MAXNET_ITER_REPORT_EN
        return {8'(inits), 8'(upd), 8'(fin), 6'(iter), rv, err};
`else
        return {8'(inits), 8'(upd), 8'(fin), 6'd0, rv, err};
`endif
    endfunction

    // Monitor
    bit in_run = 0;
    int m_cyc, m_inits, m_upd, m_rvcnt;
    bit rv_last, err_last;
    int m_iter;

    always @(negedge clk) begin
        if (!rst) begin
            in_run = 0;
        end else begin
            chk("ldx_implies_load", ld_x ? {ld_t, sel_t, busy} : 3'b111, 3'b111);
            chk("selt_only_init", sel_t ? ld_x : 1'b1, 1'b1);
            chk("idle_quiet", busy ? 4'd0 : {ld_x, ld_t, sel_t, result_valid}, 4'd0);
            if (ld_x) begin
                if (!in_run) begin
                    in_run  = 1;
                    m_cyc   = 0;
                    m_inits = 0;
                    m_upd   = 0;
                    m_rvcnt = 0;
                end
                m_inits++;
            end
            if (in_run) begin
                if (busy) begin
                    m_cyc++;
                    if (ld_t && !sel_t) m_upd++;
                    if (result_valid) m_rvcnt++;
                    rv_last  = result_valid;
                    err_last = error;
                end else begin
`ifdef MAXNET_ITER_REPORT_EN
                    m_iter = int'(iter_count);
`else
                    m_iter = 0;
`endif
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_run: got a run with no expectation queued");
                    end else begin
                        chk("run_record", pack(m_inits, m_upd, m_cyc, m_iter,
                                               rv_last && (m_rvcnt == 1), err_last),
                            exp_q.pop_front());
                    end
                    in_run = 0;
                end
            end
        end
    end

    // Driver: k = number of UPDATE pulses after which done rises (0 = already high).
    task automatic run(input int k, input bit noise, input logic [31:0] exp);
        int n_upd = 0;
        bit ended = 0;
        exp_q.push_back(exp);
        done = (k == 0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("init_ldx_error_clear", {ld_x, error}, 2'b10);
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (!busy) begin
                ended = 1;
                start = 1'b0;
                break;
            end
            if (ld_t && !sel_t) begin
                n_upd++;
                if (n_upd == k) done = 1'b1;
            end
            start = noise && c[0];
        end
        if (!ended) begin
            checks++;
            errors++;
            $display("FAIL run_timeout: busy still %0b after 200 cycles, required 0", busy);
        end
        done  = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #12;
        chk("reset_outputs", {ld_x, ld_t, sel_t, busy, result_valid, error}, 6'd0);
        chk("reset_state", state_dbg, 3'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        run(0, 0, pack(1, 0, 3, 0, 1'b1, 1'b0));     // immediate winner
        run(3, 0, pack(1, 3, 15, 3, 1'b1, 1'b0));    // three passes
        run(99, 0, pack(1, 4, 19, 4, 1'b0, 1'b1));   // timeout at MAX_ITER
        repeat (3) @(negedge clk);
        chk("error_sticky_idle", {busy, error}, 2'b01);
        run(1, 1, pack(1, 1, 7, 1, 1'b1, 1'b0));     // start noise while busy
        run(4, 0, pack(1, 4, 19, 4, 1'b1, 1'b0));    // done wins at the cap

        // Reset in the middle of WAIT
        done = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("in_wait_before_reset", state_dbg, 3'd3);
        #2 rst = 1'b0;
        #1;
        chk("midrun_reset_outputs", {ld_x, ld_t, sel_t, busy, result_valid, error}, 6'd0);
        chk("midrun_reset_state", state_dbg, 3'd0);
`ifdef MAXNET_ITER_REPORT_EN
        chk("midrun_reset_iter", iter_count, 0);
`endif
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        run(2, 0, pack(1, 2, 11, 2, 1'b1, 1'b0));    // recovery after reset
        repeat (3) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
